seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver used across the lab boards.
- Watches the active-low anode/segment scan bus (DIGIT/DISPLAY style) and recovers the four displayed characters and the 3-digit numeric value.
- Used as an on-chip monitor and board-to-board link checker: a second board samples another board's display pins; in simulation it serves as a self-checking display observer.

---
 rtl/seg7_scan_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment scan bus.
// Define SEG7_SCAN_ERRCNT_EN to build the saturating err_count counter.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] seg_digit_n,
    input  logic [6:0] seg_display_n,
    output logic [3:0] char0,
    output logic [3:0] char1,
    output logic [3:0] char2,
    output logic [3:0] char3,
    output logic [9:0] value,
    output logic       value_valid,
    output logic       arrow_up,
    output logic       arrow_down,
    output logic       frame_done,
    output logic       err_pulse,
    output logic       stale,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, STALE} state_t;

    localparam logic [7:0] SETTLE    = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_BITS-1:0] IDLE_MAX  = '1;
    localparam logic [TIMEOUT_BITS-1:0] IDLE_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_BITS-1:0] IDLE_ONE  = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

    logic [3:0]  digit_s1, digit_s2;
    logic [6:0]  disp_s1, disp_s2;
    logic [10:0] prev_bus;
    logic [7:0]  stable_cnt;
    logic [TIMEOUT_BITS-1:0] idle_cnt;

    state_t      state;
    logic [3:0]  seen;
    logic [3:0]  shadow [4];

    logic        bus_same, fire;
    logic        anode_ok, anode_blank;
    logic [1:0]  pos;
    logic [3:0]  pos_bit;
    logic [3:0]  code;
    logic        seg_ok;
    logic        valid_sample, err_now;
    logic        frame_digits_ok;
    logic [9:0]  frame_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_s1   <= '1;
            digit_s2   <= '1;
            disp_s1    <= '1;
            disp_s2    <= '1;
            prev_bus   <= '1;
            stable_cnt <= '0;
        end else begin
            digit_s1 <= seg_digit_n;
            digit_s2 <= digit_s1;
            disp_s1  <= seg_display_n;
            disp_s2  <= disp_s1;
            prev_bus <= {digit_s2, disp_s2};
            if (!bus_same)
                stable_cnt <= '0;
            else if (stable_cnt != SETTLE)
                stable_cnt <= stable_cnt + 8'd1;
        end
    end

    // Sample exactly once per dwell: on the step that takes stable_cnt to SETTLE.
    assign bus_same = ({digit_s2, disp_s2} == prev_bus);
    assign fire     = bus_same && (stable_cnt == SETTLE_M1);

    always_comb begin
        anode_ok    = 1'b1;
        anode_blank = 1'b0;
        pos         = 2'd0;
        case (digit_s2)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            4'b1111: begin
                anode_ok    = 1'b0;
                anode_blank = 1'b1;
            end
            default: anode_ok = 1'b0;
        endcase
    end

    always_comb begin
        seg_ok = 1'b1;
        code   = 4'd12;
        case (disp_s2)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b0111111: code = 4'd10;
            7'b1011100: code = 4'd14;
            7'b1100011: code = 4'd15;
            7'b1111111: code = 4'd11;
            default:    seg_ok = 1'b0;
        endcase
    end

    assign pos_bit      = 4'b0001 << pos;
    assign valid_sample = fire && anode_ok;
    assign err_now      = fire && ((!anode_ok && !anode_blank) || (anode_ok && !seg_ok));

    assign frame_digits_ok = (shadow[0] <= 4'd9) && (shadow[1] <= 4'd9) && (shadow[2] <= 4'd9);
    assign frame_value     = 10'(shadow[2]) * 10'd100 + 10'(shadow[1]) * 10'd10 + 10'(shadow[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            seen        <= '0;
            idle_cnt    <= '0;
            for (int unsigned i = 0; i < 4; i++) shadow[i] <= 4'd11;
            char0       <= 4'd11;
            char1       <= 4'd11;
            char2       <= 4'd11;
            char3       <= 4'd11;
            value       <= '0;
            value_valid <= 1'b0;
            arrow_up    <= 1'b0;
            arrow_down  <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            stale       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_pulse  <= err_now;

            if (valid_sample)
                idle_cnt <= '0;
            else if (state != IDLE && idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + IDLE_ONE;

            if (valid_sample)
                shadow[pos] <= code;

            case (state)
                IDLE: begin
                    if (valid_sample) begin
                        state <= COLLECT;
                        seen  <= pos_bit;
                    end
                end
                COLLECT: begin
                    // Publishing reads the old shadow; a sample landing now opens the next frame.
                    if (seen == 4'b1111) begin
                        char0       <= shadow[0];
                        char1       <= shadow[1];
                        char2       <= shadow[2];
                        char3       <= shadow[3];
                        value_valid <= frame_digits_ok;
                        if (frame_digits_ok)
                            value <= frame_value;
                        arrow_up    <= (shadow[3] == 4'd14);
                        arrow_down  <= (shadow[3] == 4'd15);
                        frame_done  <= 1'b1;
                        seen        <= valid_sample ? pos_bit : 4'b0000;
                    end else if (valid_sample) begin
                        seen <= seen | pos_bit;
                    end
                    if (!valid_sample && idle_cnt == IDLE_LAST) begin
                        state <= STALE;
                        stale <= 1'b1;
                        seen  <= '0;
                    end
                end
                STALE: begin
                    if (valid_sample) begin
                        state <= COLLECT;
                        stale <= 1'b0;
                        seen  <= pos_bit;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEG7_SCAN_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (err_pulse && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random frames
// checked against a character-level frame model.
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TBITS  = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] seg_digit_n;
    logic [6:0] seg_display_n;
    logic [3:0] char0, char1, char2, char3;
    logic [9:0] value;
    logic       value_valid, arrow_up, arrow_down, frame_done, err_pulse, stale;
    logic [7:0] err_count;

    seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_BITS(TBITS)) dut (
        .clk(clk), .rst(rst), .seg_digit_n(seg_digit_n), .seg_display_n(seg_display_n),
        .char0(char0), .char1(char1), .char2(char2), .char3(char3),
        .value(value), .value_valid(value_valid), .arrow_up(arrow_up), .arrow_down(arrow_down),
        .frame_done(frame_done), .err_pulse(err_pulse), .stale(stale), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int fd_seen = 0, err_seen = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_seen++;
        if (err_pulse === 1'b1) err_seen++;
    end

    // Frame model: characters per position, published when all four are seen.
    int   m_shadow [4];
    int   m_char   [4];
    int   m_seen, m_value, m_frames, m_errs, m_errcnt;
    logic m_valid, m_up, m_down, m_stale;
    logic [10:0] last_bus = '1;

    logic [29:0] act_vec;
    assign act_vec = {char3, char2, char1, char0, value, value_valid, arrow_up, arrow_down, stale};

    function automatic logic [29:0] exp_vec();
        exp_vec = {4'(m_char[3]), 4'(m_char[2]), 4'(m_char[1]), 4'(m_char[0]),
                   10'(m_value), m_valid, m_up, m_down, m_stale};
    endfunction

    function automatic logic [7:0] exp_errcnt();
`ifdef SEG7_SCAN_ERRCNT_EN
        exp_errcnt = (m_errcnt > 255) ? 8'd255 : 8'(m_errcnt);
`else
        exp_errcnt = 8'd0;
`endif
    endfunction

    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;  2: seg_of = 7'b0100100;
            3: seg_of = 7'b0110000;  4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
            6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;  8: seg_of = 7'b0000000;
            9: seg_of = 7'b0010000; 10: seg_of = 7'b0111111; 14: seg_of = 7'b1011100;
            15: seg_of = 7'b1100011; default: seg_of = 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] anode_of(input int pos);
        logic [3:0] a;
        a = 4'b0001 << pos;
        anode_of = ~a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 11;
            m_char[i]   = 11;
        end
        m_seen = 0; m_value = 0; m_errcnt = 0;
        m_valid = 0; m_up = 0; m_down = 0; m_stale = 0;
    endtask

    task automatic model_sample(input int pos, input int code);
        m_stale = 0;
        m_shadow[pos] = code;
        m_seen = m_seen | (1 << pos);
        if (m_seen == 15) begin
            for (int i = 0; i < 4; i++) m_char[i] = m_shadow[i];
            m_valid = (m_char[0] <= 9) && (m_char[1] <= 9) && (m_char[2] <= 9);
            if (m_valid) m_value = m_char[2] * 100 + m_char[1] * 10 + m_char[0];
            m_up   = (m_char[3] == 14);
            m_down = (m_char[3] == 15);
            m_frames++;
            m_seen = 0;
        end
    endtask

    // A repeated pattern would merge into one dwell, so separate it with a blank slot.
    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        if ({d, s} == last_bus && d != 4'hF) begin
            seg_digit_n = 4'hF; seg_display_n = 7'h7F;
            repeat (10) @(posedge clk);
            #1;
        end
        seg_digit_n = d; seg_display_n = s; last_bus = {d, s};
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int pos, input int code, input int n);
        drive(anode_of(pos), seg_of(code), n);
        model_sample(pos, code);
    endtask

    task automatic show_bad_seg(input int pos, input logic [6:0] s, input int n);
        drive(anode_of(pos), s, n);
        m_errs++; m_errcnt++;
        model_sample(pos, 12);
    endtask

    task automatic show_bad_anode(input logic [3:0] d, input int n);
        drive(d, seg_of(1), n);
        m_errs++; m_errcnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; seg_digit_n = 4'hF; seg_display_n = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if ({frame_done, err_pulse, err_count} !== 10'd0) begin
            n_bad++; $display("FAIL reset_pulses: got %b expected 0", {frame_done, err_pulse, err_count});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        show(0, 5, 20); show(1, 0, 20); show(2, 0, 20);
        n_vec++;
        if (fd_seen !== m_frames) begin
            n_bad++; $display("FAIL basic_partial_frames: got %0d expected %0d", fd_seen, m_frames);
        end
        show(3, 14, 20);
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL basic_frame: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if (fd_seen !== m_frames) begin
            n_bad++; $display("FAIL basic_frame_done: got %0d expected %0d", fd_seen, m_frames);
        end
    endtask

    task automatic test_dash();
        for (int p = 0; p < 4; p++) show(p, 10, 20);
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL dash_frame: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if (fd_seen !== m_frames) begin
            n_bad++; $display("FAIL dash_frame_done: got %0d expected %0d", fd_seen, m_frames);
        end
    endtask

    task automatic test_glitch();
        show(0, 9, 20); show(1, 9, 20); show(2, 9, 20); show(3, 11, 20);
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL value_999: got %h expected %h", act_vec, exp_vec());
        end
        drive(anode_of(0), seg_of(3), 3);
        drive(anode_of(0), 7'b1010101, 2);
        show(0, 3, 20); show(1, 4, 20); show(2, 5, 20); show(3, 11, 20);
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL glitch_frame: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if (err_seen !== m_errs || fd_seen !== m_frames) begin
            n_bad++; $display("FAIL glitch_counts: got err=%0d fd=%0d expected err=%0d fd=%0d",
                              err_seen, fd_seen, m_errs, m_frames);
        end
    endtask

    task automatic test_errors();
        show_bad_anode(4'b1100, 20);
        show(0, 1, 20); show_bad_seg(1, 7'b1010101, 20); show(2, 2, 20); show(3, 15, 20);
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL error_frame: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if (err_seen !== m_errs) begin
            n_bad++; $display("FAIL err_pulses: got %0d expected %0d", err_seen, m_errs);
        end
        n_vec++;
        if (err_count !== exp_errcnt()) begin
            n_bad++; $display("FAIL err_count: got %0d expected %0d", err_count, exp_errcnt());
        end
    endtask

    task automatic test_timeout();
        int fd0;
        show(0, 6, 20); show(1, 7, 20); show(2, 8, 20);
        fd0 = fd_seen;
        // Last sample lands 7 edges into the third slot; stale rises 63 edges later.
        drive(4'hF, 7'h7F, 49);
        n_vec++;
        if (stale !== 1'b0) begin
            n_bad++; $display("FAIL stale_early: got %b expected 0", stale);
        end
        @(posedge clk);
        #1;
        m_stale = 1; m_seen = 0;
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL stale_entry: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if (fd_seen !== fd0) begin
            n_bad++; $display("FAIL stale_no_frame: got %0d expected %0d", fd_seen, fd0);
        end
        show(0, 1, 20);
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL stale_exit: got %h expected %h", act_vec, exp_vec());
        end
        show(1, 2, 20); show(2, 3, 20);
        n_vec++;
        if (fd_seen !== fd0) begin
            n_bad++; $display("FAIL resume_partial: got %0d expected %0d", fd_seen, fd0);
        end
        show(3, 14, 20);
        n_vec++;
        if (act_vec !== exp_vec() || fd_seen !== m_frames) begin
            n_bad++; $display("FAIL resume_frame: got %h fd=%0d expected %h fd=%0d",
                              act_vec, fd_seen, exp_vec(), m_frames);
        end
    endtask

    task automatic test_reset_midframe();
        int fd0;
        show(0, 7, 20); show(1, 3, 20);
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL async_reset: got %h expected %h", act_vec, exp_vec());
        end
        n_vec++;
        if (err_count !== 8'd0 || frame_done !== 1'b0 || err_pulse !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_flags: got %0d/%b/%b expected 0/0/0",
                              err_count, frame_done, err_pulse);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fd0 = fd_seen;
        show(2, 4, 20); show(3, 11, 20);
        n_vec++;
        if (fd_seen !== fd0 || act_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_no_carry: got %h fd=%0d expected %h fd=%0d",
                              act_vec, fd_seen, exp_vec(), fd0);
        end
        show(0, 2, 20); show(1, 6, 20);
        n_vec++;
        if (act_vec !== exp_vec() || fd_seen !== fd0 + 1) begin
            n_bad++; $display("FAIL reset_fresh_frame: got %h fd=%0d expected %h fd=%0d",
                              act_vec, fd_seen, exp_vec(), fd0 + 1);
        end
    endtask

    task automatic test_random();
        logic [3:0] bad_anodes [4];
        logic [6:0] bad_segs   [4];
        int perm [4];
        int idx, code, tmp, j;
        bad_anodes = '{4'b1100, 4'b0000, 4'b1001, 4'b0101};
        bad_segs   = '{7'b1010101, 7'b0000001, 7'b1110111, 7'b0101010};
        for (int f = 0; f < 40; f++) begin
            perm = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 7))
                    0: show_bad_anode(bad_anodes[$urandom_range(0, 3)], $urandom_range(10, 14));
                    1: drive(4'hF, 7'($urandom), $urandom_range(10, 14));
                    2: show($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(10, 14));
                    default: ;
                endcase
                if ($urandom_range(0, 11) == 0) begin
                    show_bad_seg(perm[k], bad_segs[$urandom_range(0, 3)], $urandom_range(10, 25));
                end else begin
                    idx  = $urandom_range(0, 13);
                    code = (idx < 12) ? idx : ((idx == 12) ? 14 : 15);
                    show(perm[k], code, $urandom_range(10, 25));
                end
                n_vec++;
                if (act_vec !== exp_vec()) begin
                    n_bad++; $display("FAIL random_slot f%0d k%0d: got %h expected %h", f, k, act_vec, exp_vec());
                end
            end
            n_vec++;
            if (fd_seen !== m_frames || err_seen !== m_errs || err_count !== exp_errcnt()) begin
                n_bad++; $display("FAIL random_counts f%0d: got fd=%0d err=%0d cnt=%0d expected fd=%0d err=%0d cnt=%0d",
                                  f, fd_seen, err_seen, err_count, m_frames, m_errs, exp_errcnt());
            end
        end
    endtask

    initial begin
        m_frames = 0; m_errs = 0;
        test_reset();
        test_basic_frame();
        test_dash();
        test_glitch();
        test_errors();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
